dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Data-memory access controller sitting directly downstream of the store unit (and the load unit) in the execute/memory stage. Captures a single core-side access (addr, write data, byte enables, read/write mode) and runs it on the external data-memory bus using a valid/ready request plus response handshake. Holds the core stalled until the response or a timeout arrives, then returns read data, lane-masked by the byte enables, along with an error status.

Parameters:
TIMEOUT_CYCLES, 64, max cycles spent in REQ+RSP before the access is aborted with error (min 2)
CNT_W, $clog2(TIMEOUT_CYCLES)+1, timeout counter width (derived, not overridden)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-low reset
i_req_valid  in  1  core access request (store unit drives it when store_control != STR_NOP)
i_rw_mode  in  1  0 = write, 1 = read (same encoding as store unit mem_rw_mode)
i_addr  in  32  byte address
i_wdata  in  32  lane-aligned write data
i_byte_en  in  4  lane enables
o_stall  out  1  core stall: holds PC while access pending
o_done  out  1  one-cycle completion pulse
o_rdata  out  32  read data, disabled lanes zero; 0 for writes
o_err  out  1  valid with o_done: bus error, timeout or illegal request
o_timeout  out  1  valid with o_done: abort caused by timeout
o_bus_valid  out  1  bus request valid
i_bus_ready  in  1  bus accepts request
o_bus_we  out  1  1 = write
o_bus_addr  out  32  {addr[31:2],2'b00}
o_bus_wdata  out  32  write data
o_bus_be  out  4  byte enables
i_bus_rsp_valid  in  1  response valid (sent for reads and writes)
i_bus_rdata  in  32  response data
i_bus_err  in  1  response error, valid with i_bus_rsp_valid

Behaviour:
- Reset (async, i_rst=0): state IDLE; all registered outputs 0, including o_bus_valid, o_done, o_err, o_timeout, o_rdata, and bus payload; counter 0. A reset mid-access drops o_bus_valid immediately and discards the access.
- States: IDLE, REQ, RSP, DONE.
- IDLE: when i_req_valid=1, register we=~i_rw_mode, addr, wdata and be, then go to REQ. Exception: a write with i_byte_en=4'b0000 goes straight to DONE with o_err=1 and no bus traffic.
- REQ: o_bus_valid=1 with payload held stable from the captured registers. On i_bus_ready=1, go to RSP. If i_bus_rsp_valid is also 1 in the same cycle (zero-wait memory), capture the response and go to DONE.
- RSP: on i_bus_rsp_valid=1, capture o_err=i_bus_err. For reads, o_rdata = i_bus_rdata with lanes where be=0 forced to 0; for writes, o_rdata=0. Go to DONE.
- DONE: o_done=1 for exactly one cycle, then go to IDLE. i_req_valid is ignored in DONE; the requester must drop or replace the request in this cycle.
- o_stall (combinational) = (state==IDLE & i_req_valid) | state==REQ | state==RSP. It is 0 in DONE. Best-case access is REQ→DONE: stall covers 2 cycles and o_done is high 2 cycles after the request is seen.
- Timeout: the counter clears on entry to REQ and increments each cycle in REQ or RSP. When it reaches TIMEOUT_CYCLES-1 with no progress, go to DONE with o_err=1, o_timeout=1, o_rdata=0, and drop o_bus_valid.
- Progress wins over timeout when both happen in the same cycle.
- i_bus_rsp_valid is ignored in IDLE and DONE (stray or late responses). i_bus_ready is ignored outside REQ.
- o_err, o_timeout and o_rdata hold their values until the next access enters DONE.

Decomposition:
- processor_defines.sv gets:
  - dmem_state_t enum (IDLE/REQ/RSP/DONE)
  - MEM_WRITE=1'b0 and MEM_READ=1'b1 constants
  - lane-mask helper function (be → 32-bit mask)
- One sub-module, dmem_timeout_cnt: clear, enable, expired output, parameter TIMEOUT_CYCLES.

Test Plan:
- SW at addr 0x100, wdata 0xDEADBEEF, be 1111, bus_ready on the first REQ cycle, rsp next cycle → bus_addr 0x100, bus_we=1, o_done 3 cycles after request, o_err=0, o_rdata=0.
- SB at addr 0x203 (be 1000, wdata 0xAB000000), ready delayed 5 cycles → payload stable for all 5 cycles, bus_addr 0x200, o_stall high throughout, single o_done pulse.
- Read, be 0011, bus returns rdata 0x12345678 with ready+rsp in the same cycle → DONE directly from REQ, o_rdata=0x00005678.
- Read with i_bus_err=1 on response → o_err=1, o_timeout=0. Write with be=0000 → o_done next cycle, o_err=1, o_bus_valid never asserted.
- TIMEOUT_CYCLES=8, never assert ready → o_bus_valid drops and o_done, o_err=1, o_timeout=1 fire after 8 cycles. A late rsp_valid afterwards is ignored.
- Assert i_rst=0 while in RSP → o_bus_valid and o_stall go to 0 asynchronously and state returns to IDLE. After release, a new SW completes normally.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    localparam logic MEM_WRITE = 1'b0;
    localparam logic MEM_READ  = 1'b1;

    // Expand per-byte enables into a 32-bit data mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Access watchdog: counts cycles while enabled and flags the last allowed cycle.
module dmem_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = i_enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: one core access at a time onto a valid/ready
// request bus with a separate response phase, guarded by a timeout.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_rw_mode,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_byte_en,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_timeout,
    output logic        o_bus_valid,
    input  logic        i_bus_ready,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_rsp_valid,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_err
);

    dmem_state_t state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        timeout_q, timeout_d;

    logic        busy;
    logic        expired;
    logic [31:0] rsp_rdata;

    assign busy      = (state_q == REQ) || (state_q == RSP);
    assign rsp_rdata = we_q ? 32'h0 : (i_bus_rdata & lane_mask(be_q));

    dmem_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (!busy),
        .i_enable (busy),
        .o_expired(expired)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    // A write that touches no lanes is rejected without bus traffic.
                    if ((i_rw_mode == MEM_WRITE) && (i_byte_en == 4'b0000)) begin
                        state_d   = DONE;
                        err_d     = 1'b1;
                        timeout_d = 1'b0;
                        rdata_d   = 32'h0;
                    end else begin
                        state_d = REQ;
                        we_d    = (i_rw_mode != MEM_READ);
                        addr_d  = i_addr;
                        wdata_d = i_wdata;
                        be_d    = i_byte_en;
                    end
                end
            end
            REQ: begin
                if (i_bus_ready && i_bus_rsp_valid) begin
                    state_d   = DONE;
                    err_d     = i_bus_err;
                    timeout_d = 1'b0;
                    rdata_d   = rsp_rdata;
                end else if (i_bus_ready) begin
                    state_d = RSP;
                end else if (expired) begin
                    state_d   = DONE;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    rdata_d   = 32'h0;
                end
            end
            RSP: begin
                if (i_bus_rsp_valid) begin
                    state_d   = DONE;
                    err_d     = i_bus_err;
                    timeout_d = 1'b0;
                    rdata_d   = rsp_rdata;
                end else if (expired) begin
                    state_d   = DONE;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    rdata_d   = 32'h0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_stall     = ((state_q == IDLE) && i_req_valid) || busy;
    assign o_done      = (state_q == DONE);
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;
    assign o_timeout   = timeout_q;
    assign o_bus_valid = (state_q == REQ);
    assign o_bus_we    = we_q;
    assign o_bus_addr  = addr_q & 32'hFFFF_FFFC;
    assign o_bus_wdata = wdata_q;
    assign o_bus_be    = be_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl; completion results are tracked in a scoreboard queue.
module tb_dmem_ctrl;

    typedef struct {
        logic        err;
        logic        tmo;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        rw_mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        o_stall, o_done, o_err, o_timeout;
    logic [31:0] o_rdata;
    logic        o_bus_valid, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        bus_ready, rsp_valid, bus_err;
    logic [31:0] bus_rdata;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .i_rw_mode      (rw_mode),
        .i_addr         (addr),
        .i_wdata        (wdata),
        .i_byte_en      (be),
        .o_stall        (o_stall),
        .o_done         (o_done),
        .o_rdata        (o_rdata),
        .o_err          (o_err),
        .o_timeout      (o_timeout),
        .o_bus_valid    (o_bus_valid),
        .i_bus_ready    (bus_ready),
        .o_bus_we       (o_bus_we),
        .o_bus_addr     (o_bus_addr),
        .o_bus_wdata    (o_bus_wdata),
        .o_bus_be       (o_bus_be),
        .i_bus_rsp_valid(rsp_valid),
        .i_bus_rdata    (bus_rdata),
        .i_bus_err      (bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (o_done === 1'b1) begin
                cyc = i;
                return;
            end
            step();
        end
    endtask

    task automatic sb_pop(output exp_t e);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        else e = '{err: 1'bx, tmo: 1'bx, rdata: 32'hx};
    endtask

    task automatic drive_req(input logic rw, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b);
        req_valid = 1'b1;
        rw_mode   = rw;
        addr      = a;
        wdata     = d;
        be        = b;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; rw_mode = 1'b0; addr = '0; wdata = '0; be = '0;
        bus_ready = 1'b0; rsp_valid = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        #3;
        n_checks++; if (o_bus_valid !== 1'b0) $display("FAIL rst_bus_valid: got %b want 0", o_bus_valid); else n_pass++;
        n_checks++; if (o_done !== 1'b0) $display("FAIL rst_done: got %b want 0", o_done); else n_pass++;
        n_checks++; if ({o_err, o_timeout} !== 2'b00) $display("FAIL rst_err_tmo: got %b want 00", {o_err, o_timeout}); else n_pass++;
        n_checks++; if (o_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", o_rdata); else n_pass++;
        n_checks++; if (o_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", o_stall); else n_pass++;
        n_checks++; if ({o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be} !== 69'h0)
            $display("FAIL rst_payload: got %b %h %h %h want zeros", o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be); else n_pass++;
        step(); step();
        #2 rst = 1'b1;
        step();
    endtask

    task automatic test_sw();
        exp_t e;
        drive_req(1'b0, 32'h100, 32'hDEADBEEF, 4'hF);
        sb_q.push_back('{err: 1'b0, tmo: 1'b0, rdata: 32'h0});
        #1;
        n_checks++; if (o_stall !== 1'b1) $display("FAIL sw_stall_idle: got %b want 1", o_stall); else n_pass++;
        step();
        n_checks++;
        if ({o_bus_valid, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF})
            $display("FAIL sw_payload: got v=%b we=%b a=%h d=%h be=%h want 1 1 100 deadbeef f",
                     o_bus_valid, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be);
        else n_pass++;
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        rsp_valid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        step();
        rsp_valid = 1'b0;
        n_checks++; if (o_done !== 1'b1) $display("FAIL sw_done_latency: got %b want 1 at cycle 3", o_done); else n_pass++;
        sb_pop(e);
        n_checks++; if ({o_err, o_timeout, o_rdata} !== {e.err, e.tmo, e.rdata})
            $display("FAIL sw_result: got err=%b tmo=%b rdata=%h want %b %b %h", o_err, o_timeout, o_rdata, e.err, e.tmo, e.rdata);
        else n_pass++;
        req_valid = 1'b0;
        step();
        n_checks++; if (o_done !== 1'b0) $display("FAIL sw_done_pulse: got %b want 0", o_done); else n_pass++;
    endtask

    task automatic test_sb_delayed();
        exp_t e;
        int   bad, cyc;
        drive_req(1'b0, 32'h203, 32'hAB00_0000, 4'b1000);
        sb_q.push_back('{err: 1'b0, tmo: 1'b0, rdata: 32'h0});
        step();
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (!(o_bus_valid === 1'b1 && o_bus_we === 1'b1 && o_bus_addr === 32'h200 &&
                  o_bus_wdata === 32'hAB00_0000 && o_bus_be === 4'b1000 && o_stall === 1'b1)) bad++;
            step();
        end
        n_checks++; if (bad !== 0) $display("FAIL sb_payload_stable: got %0d bad cycles want 0", bad); else n_pass++;
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        n_checks++; if ({o_stall, o_bus_valid} !== 2'b10) $display("FAIL sb_rsp_phase: got stall=%b valid=%b want 1 0", o_stall, o_bus_valid); else n_pass++;
        rsp_valid = 1'b1; bus_rdata = 32'h1234_5678;
        step();
        rsp_valid = 1'b0;
        wait_done(4, cyc);
        n_checks++; if (cyc !== 0) $display("FAIL sb_done: got wait %0d want 0", cyc); else n_pass++;
        n_checks++; if (o_stall !== 1'b0) $display("FAIL sb_stall_done: got %b want 0", o_stall); else n_pass++;
        sb_pop(e);
        n_checks++; if ({o_err, o_timeout, o_rdata} !== {e.err, e.tmo, e.rdata})
            $display("FAIL sb_result: got err=%b tmo=%b rdata=%h want %b %b %h", o_err, o_timeout, o_rdata, e.err, e.tmo, e.rdata);
        else n_pass++;
        req_valid = 1'b0;
        step();
        n_checks++; if (o_done !== 1'b0) $display("FAIL sb_single_pulse: got %b want 0", o_done); else n_pass++;
    endtask

    task automatic test_read_err();
        exp_t e;
        int   cyc;
        drive_req(1'b1, 32'h48, 32'h0, 4'hF);
        sb_q.push_back('{err: 1'b1, tmo: 1'b0, rdata: 32'hCAFE_F00D});
        step();
        n_checks++; if (o_bus_we !== 1'b0) $display("FAIL rderr_we: got %b want 0", o_bus_we); else n_pass++;
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        rsp_valid = 1'b1; bus_err = 1'b1; bus_rdata = 32'hCAFE_F00D;
        step();
        rsp_valid = 1'b0; bus_err = 1'b0;
        wait_done(2, cyc);
        n_checks++; if (cyc !== 0) $display("FAIL rderr_done: got wait %0d want 0", cyc); else n_pass++;
        sb_pop(e);
        n_checks++; if ({o_err, o_timeout, o_rdata} !== {e.err, e.tmo, e.rdata})
            $display("FAIL rderr_result: got err=%b tmo=%b rdata=%h want %b %b %h", o_err, o_timeout, o_rdata, e.err, e.tmo, e.rdata);
        else n_pass++;
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_read_zero_wait();
        exp_t e;
        drive_req(1'b1, 32'h44, 32'h0, 4'b0011);
        sb_q.push_back('{err: 1'b0, tmo: 1'b0, rdata: 32'h0000_5678});
        step();
        bus_ready = 1'b1; rsp_valid = 1'b1; bus_rdata = 32'h1234_5678;
        step();
        bus_ready = 1'b0; rsp_valid = 1'b0;
        n_checks++; if (o_done !== 1'b1) $display("FAIL zw_done_cycle2: got %b want 1", o_done); else n_pass++;
        sb_pop(e);
        n_checks++; if ({o_err, o_timeout, o_rdata} !== {e.err, e.tmo, e.rdata})
            $display("FAIL zw_result: got err=%b tmo=%b rdata=%h want %b %b %h", o_err, o_timeout, o_rdata, e.err, e.tmo, e.rdata);
        else n_pass++;
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal_write();
        exp_t e;
        logic seen_valid;
        drive_req(1'b0, 32'h50, 32'h1111_2222, 4'b0000);
        sb_q.push_back('{err: 1'b1, tmo: 1'b0, rdata: 32'h0});
        #1;
        seen_valid = o_bus_valid;
        step();
        seen_valid |= o_bus_valid;
        n_checks++; if (o_done !== 1'b1) $display("FAIL ill_done_next: got %b want 1", o_done); else n_pass++;
        sb_pop(e);
        n_checks++; if ({o_err, o_timeout, o_rdata} !== {e.err, e.tmo, e.rdata})
            $display("FAIL ill_result: got err=%b tmo=%b rdata=%h want %b %b %h", o_err, o_timeout, o_rdata, e.err, e.tmo, e.rdata);
        else n_pass++;
        req_valid = 1'b0;
        step();
        seen_valid |= o_bus_valid;
        n_checks++; if (seen_valid !== 1'b0) $display("FAIL ill_no_bus: got valid seen=%b want 0", seen_valid); else n_pass++;
    endtask

    task automatic test_timeout();
        exp_t e;
        int   bad;
        drive_req(1'b1, 32'h80, 32'h0, 4'hF);
        sb_q.push_back('{err: 1'b1, tmo: 1'b1, rdata: 32'h0});
        step();
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (o_bus_valid !== 1'b1 || o_done !== 1'b0) bad++;
            step();
        end
        n_checks++; if (bad !== 0) $display("FAIL tmo_window: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if ({o_done, o_bus_valid} !== 2'b10) $display("FAIL tmo_fire: got done=%b valid=%b want 1 0", o_done, o_bus_valid); else n_pass++;
        sb_pop(e);
        n_checks++; if ({o_err, o_timeout, o_rdata} !== {e.err, e.tmo, e.rdata})
            $display("FAIL tmo_result: got err=%b tmo=%b rdata=%h want %b %b %h", o_err, o_timeout, o_rdata, e.err, e.tmo, e.rdata);
        else n_pass++;
        req_valid = 1'b0;
        rsp_valid = 1'b1; bus_rdata = 32'h1111_1111;
        step();
        step();
        rsp_valid = 1'b0;
        n_checks++; if ({o_done, o_stall, o_bus_valid} !== 3'b000)
            $display("FAIL tmo_late_rsp_ctl: got done=%b stall=%b valid=%b want 000", o_done, o_stall, o_bus_valid); else n_pass++;
        n_checks++; if ({o_err, o_timeout, o_rdata} !== {1'b1, 1'b1, 32'h0})
            $display("FAIL tmo_late_rsp_hold: got err=%b tmo=%b rdata=%h want 1 1 0", o_err, o_timeout, o_rdata); else n_pass++;
    endtask

    task automatic test_reset_mid_rsp();
        exp_t e;
        int   cyc;
        drive_req(1'b0, 32'h300, 32'h55AA_55AA, 4'hF);
        step();
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        req_valid = 1'b0;
        n_checks++; if (o_stall !== 1'b1) $display("FAIL rstrsp_stall_before: got %b want 1", o_stall); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({o_stall, o_bus_valid, o_done} !== 3'b000)
            $display("FAIL rstrsp_async: got stall=%b valid=%b done=%b want 000", o_stall, o_bus_valid, o_done); else n_pass++;
        n_checks++; if ({o_err, o_timeout} !== 2'b00) $display("FAIL rstrsp_status: got %b want 00", {o_err, o_timeout}); else n_pass++;
        step();
        #2 rst = 1'b1;
        step();
        n_checks++; if ({o_done, o_stall} !== 2'b00) $display("FAIL rstrsp_idle: got done=%b stall=%b want 00", o_done, o_stall); else n_pass++;
        drive_req(1'b0, 32'h400, 32'h0BAD_F00D, 4'hF);
        sb_q.push_back('{err: 1'b0, tmo: 1'b0, rdata: 32'h0});
        step();
        n_checks++; if ({o_bus_valid, o_bus_addr, o_bus_wdata} !== {1'b1, 32'h400, 32'h0BAD_F00D})
            $display("FAIL rstrsp_new_req: got v=%b a=%h d=%h want 1 400 0badf00d", o_bus_valid, o_bus_addr, o_bus_wdata); else n_pass++;
        bus_ready = 1'b1; rsp_valid = 1'b1; bus_rdata = 32'h7777_7777;
        step();
        bus_ready = 1'b0; rsp_valid = 1'b0;
        wait_done(3, cyc);
        n_checks++; if (cyc !== 0) $display("FAIL rstrsp_new_done: got wait %0d want 0", cyc); else n_pass++;
        sb_pop(e);
        n_checks++; if ({o_err, o_timeout, o_rdata} !== {e.err, e.tmo, e.rdata})
            $display("FAIL rstrsp_new_result: got err=%b tmo=%b rdata=%h want %b %b %h", o_err, o_timeout, o_rdata, e.err, e.tmo, e.rdata);
        else n_pass++;
        req_valid = 1'b0;
        step();
        n_checks++; if (sb_q.size() !== 0) $display("FAIL sb_drained: got %0d left want 0", sb_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb_delayed();
        test_read_err();
        test_read_zero_wait();
        test_illegal_write();
        test_timeout();
        test_reset_mid_rsp();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
